// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the program counter, walks each fetch
// through a req/ack instruction-memory port, and hands the fetched word to
// execute over a valid/ready handshake. JAL targets are resolved here.
// Branch and JALR targets arrive from execute as redirects.
module fetch_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] issue_count
);

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  typedef enum logic {
    REQ,
    ISSUE
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] issue_count_q, issue_count_d;

  logic [XLEN-1:0] jal_imm;
  logic [XLEN-1:0] seq_target;
  logic            handshake;

  // JAL offset is decoded from the held instruction, so the target is ready
  // by the time execute accepts it.
  always_comb begin
    jal_imm = {{(XLEN-20){instr_q[31]}}, instr_q[19:12], instr_q[20],
               instr_q[30:21], 1'b0};
    if (instr_q[6:0] == OPCODE_JAL) begin
      seq_target = (instr_pc_q + jal_imm) & ALIGN_MASK;
    end else begin
      seq_target = (instr_pc_q + XLEN'(4)) & ALIGN_MASK;
    end
  end

  assign handshake = (state_q == ISSUE) && instr_valid_q && instr_ready;

  // Next-state logic; a redirect overrides every other transition but still
  // lets a coincident handshake count as an issued instruction.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    issue_count_d = issue_count_q;

    if (handshake) begin
      issue_count_d = issue_count_q + XLEN'(1);
    end

    if (redirect_valid) begin
      pc_d          = redirect_pc & ALIGN_MASK;
      instr_valid_d = 1'b0;
      state_d       = REQ;
    end else begin
      case (state_q)
        REQ: begin
          if (imem_ack) begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            pc_d          = seq_target;
            state_d       = REQ;
          end
        end
        default: begin
          state_d = REQ;
        end
      endcase
    end
  end

  // State register; reset wins over redirect and any outstanding fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign imem_req    = (state_q == REQ) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table covering
// sequential fetch, JAL, wait states, stalls, redirects, wrap and reset,
// followed by a hand-written sequence with a bounded wait on the fetch.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] issue_count;

  int checks = 0;
  int failures = 0;

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .issue_count   (issue_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] eIpc;
    logic [31:0] ePc;
    logic [31:0] eCnt;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs[NVEC];

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JALP  = 32'h0100_006F;
  localparam logic [31:0] JALM  = 32'hFF1F_F06F;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  function automatic vec_t mkVec(
    input logic rst, input logic ack, input logic [31:0] rdata,
    input logic ready, input logic rv, input logic [31:0] rpc,
    input logic eReq, input logic [31:0] eAddr, input logic eValid,
    input logic [31:0] eInstr, input logic [31:0] eIpc,
    input logic [31:0] ePc, input logic [31:0] eCnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.rv = rv; v.rpc = rpc; v.eReq = eReq; v.eAddr = eAddr;
    v.eValid = eValid; v.eInstr = eInstr; v.eIpc = eIpc;
    v.ePc = ePc; v.eCnt = eCnt;
    return v;
  endfunction

  // Drive one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input vec_t v);
    reset          = v.rst;
    imem_ack       = v.ack;
    imem_rdata     = v.rdata;
    instr_ready    = v.ready;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d.imem_req", idx), 32'(imem_req), 32'(v.eReq));
    checkOutput($sformatf("v%0d.imem_addr", idx), imem_addr, v.eAddr);
    checkOutput($sformatf("v%0d.instr_valid", idx), 32'(instr_valid), 32'(v.eValid));
    checkOutput($sformatf("v%0d.instr", idx), instr, v.eInstr);
    checkOutput($sformatf("v%0d.instr_pc", idx), instr_pc, v.eIpc);
    checkOutput($sformatf("v%0d.pc", idx), pc, v.ePc);
    checkOutput($sformatf("v%0d.issue_count", idx), issue_count, v.eCnt);
  endtask

  initial begin
    int waited;

    //                    rst ack rdata  rdy rv rpc            req addr           vld instr ipc            pc             cnt
    // reset state
    vecs[0]  = mkVec(1, 0, NOP,  1, 0, 0,            0, 32'h0,        0, 32'h0, 32'h0,        32'h0,        0);
    // zero-wait nops, always ready: one issue every two cycles
    vecs[1]  = mkVec(0, 1, NOP,  1, 0, 0,            1, 32'h0,        0, 32'h0, 32'h0,        32'h0,        0);
    vecs[2]  = mkVec(0, 1, NOP,  1, 0, 0,            0, 32'h0,        1, NOP,   32'h0,        32'h0,        0);
    vecs[3]  = mkVec(0, 1, NOP,  1, 0, 0,            1, 32'h4,        0, NOP,   32'h0,        32'h4,        1);
    vecs[4]  = mkVec(0, 1, NOP,  1, 0, 0,            0, 32'h4,        1, NOP,   32'h4,        32'h4,        1);
    vecs[5]  = mkVec(0, 1, NOP,  1, 0, 0,            1, 32'h8,        0, NOP,   32'h4,        32'h8,        2);
    vecs[6]  = mkVec(0, 1, NOP,  1, 0, 0,            0, 32'h8,        1, NOP,   32'h8,        32'h8,        2);
    vecs[7]  = mkVec(0, 1, NOP,  1, 0, 0,            1, 32'hC,        0, NOP,   32'h8,        32'hC,        3);
    vecs[8]  = mkVec(0, 1, NOP,  1, 0, 0,            0, 32'hC,        1, NOP,   32'hC,        32'hC,        3);
    // JAL +16 at 0x10, then JAL -16 at 0x20
    vecs[9]  = mkVec(0, 1, JALP, 1, 0, 0,            1, 32'h10,       0, NOP,   32'hC,        32'h10,       4);
    vecs[10] = mkVec(0, 1, JALM, 1, 0, 0,            0, 32'h10,       1, JALP,  32'h10,       32'h10,       4);
    vecs[11] = mkVec(0, 1, JALM, 1, 0, 0,            1, 32'h20,       0, JALP,  32'h10,       32'h20,       5);
    vecs[12] = mkVec(0, 0, NOP,  1, 0, 0,            0, 32'h20,       1, JALM,  32'h20,       32'h20,       5);
    // three wait states on memory, then two stall cycles from execute
    vecs[13] = mkVec(0, 0, NOP,  0, 0, 0,            1, 32'h10,       0, JALM,  32'h20,       32'h10,       6);
    vecs[14] = mkVec(0, 0, NOP,  0, 0, 0,            1, 32'h10,       0, JALM,  32'h20,       32'h10,       6);
    vecs[15] = mkVec(0, 0, NOP,  0, 0, 0,            1, 32'h10,       0, JALM,  32'h20,       32'h10,       6);
    vecs[16] = mkVec(0, 1, NOP,  0, 0, 0,            1, 32'h10,       0, JALM,  32'h20,       32'h10,       6);
    vecs[17] = mkVec(0, 0, JUNK, 0, 0, 0,            0, 32'h10,       1, NOP,   32'h10,       32'h10,       6);
    vecs[18] = mkVec(0, 0, JUNK, 0, 0, 0,            0, 32'h10,       1, NOP,   32'h10,       32'h10,       6);
    vecs[19] = mkVec(0, 0, NOP,  1, 0, 0,            0, 32'h10,       1, NOP,   32'h10,       32'h10,       6);
    // redirect to 0x103 while an ack arrives: data discarded, pc aligned
    vecs[20] = mkVec(0, 1, JUNK, 1, 1, 32'h103,      1, 32'h14,       0, NOP,   32'h10,       32'h14,       7);
    vecs[21] = mkVec(0, 1, JALP, 1, 0, 0,            1, 32'h100,      0, NOP,   32'h10,       32'h100,      7);
    // handshake on a JAL together with redirect to 0x40
    vecs[22] = mkVec(0, 0, NOP,  1, 1, 32'h40,       0, 32'h100,      1, JALP,  32'h100,      32'h100,      7);
    // redirect to the top of memory, then a non-JAL issue wraps to 0
    vecs[23] = mkVec(0, 0, NOP,  1, 1, 32'hFFFF_FFFF, 1, 32'h40,      0, JALP,  32'h100,      32'h40,       8);
    vecs[24] = mkVec(0, 1, NOP,  1, 0, 0,            1, 32'hFFFF_FFFC, 0, JALP, 32'h100,      32'hFFFF_FFFC, 8);
    vecs[25] = mkVec(0, 0, NOP,  1, 0, 0,            0, 32'hFFFF_FFFC, 1, NOP,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 8);
    vecs[26] = mkVec(0, 0, NOP,  1, 0, 0,            1, 32'h0,        0, NOP,   32'hFFFF_FFFC, 32'h0,       9);
    // reset mid-wait drops the request immediately, stray ack while held
    vecs[27] = mkVec(1, 0, NOP,  1, 0, 0,            0, 32'h0,        0, NOP,   32'hFFFF_FFFC, 32'h0,       9);
    vecs[28] = mkVec(1, 1, JUNK, 1, 0, 0,            0, 32'h0,        0, 32'h0, 32'h0,        32'h0,        0);
    vecs[29] = mkVec(0, 0, NOP,  0, 0, 0,            1, 32'h0,        0, 32'h0, 32'h0,        32'h0,        0);
    vecs[30] = mkVec(0, 0, NOP,  0, 0, 0,            1, 32'h0,        0, 32'h0, 32'h0,        32'h0,        0);

    reset          = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Hand-written: five idle cycles with the address held, then a late ack.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      checkOutput("hold.imem_req", 32'(imem_req), 32'd1);
      checkOutput("hold.imem_addr", imem_addr, 32'h0);
    end
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0010_0093;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = JUNK;

    // Bounded wait for the fetched word to become valid.
    waited = 0;
    while (!instr_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("late.valid_seen", 32'(instr_valid), 32'd1);
    checkOutput("late.instr", instr, 32'h0010_0093);
    checkOutput("late.instr_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    checkOutput("late.pc", pc, 32'h4);
    checkOutput("late.issue_count", issue_count, 32'd1);
    checkOutput("late.instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("late.imem_addr", imem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction-fetch controller that owns the program counter and sequences each fetch through a request/acknowledge instruction-memory port. It hands fetched words to the execute stage with a valid/ready handshake. It resolves JAL targets locally and accepts redirects from execute. It sits between instruction memory and the single-instruction execute datapath, replacing the free-running PC/PC-source path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
XLEN, 32, address/data width; only 32 supported

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears the block on the next rising edge
imem_req  output  1  fetch request; held high until acknowledged
imem_addr  output  32  fetch address; equals pc while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  input  32  fetched instruction word, sampled when imem_req&imem_ack
instr_valid  output  1  instr/instr_pc hold a fetched instruction for execute
instr  output  32  fetched instruction word
instr_pc  output  32  address instr was fetched from
instr_ready  input  1  execute accepts instr this cycle when instr_valid=1
redirect_valid  input  1  execute-stage control transfer (branch/JALR) this cycle
redirect_pc  input  32  redirect target
pc  output  32  current fetch PC
issue_count  output  32  number of instructions accepted by execute, wraps mod 2^32

Behaviour:
- States: REQ, ISSUE. Reset: state=REQ, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, issue_count=0.
- imem_req=1 iff state==REQ and reset=0. The first request is raised in the cycle after reset deasserts.
- REQ: imem_addr=pc. imem_ack may arrive in the same cycle as the request (zero wait) or any number of cycles later. imem_req and imem_addr stay stable until ack.
- REQ with ack: on the next edge, instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, state<=ISSUE.
- ISSUE: instr, instr_pc and instr_valid stay stable while instr_ready=0.
- ISSUE with instr_ready=1 (handshake): on the next edge, instr_valid<=0, issue_count+=1, state<=REQ.
  - If instr[6:0]==7'b1101111 (JAL): pc <= instr_pc + J-immediate, where J-immediate = sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
  - Otherwise pc <= instr_pc + 4.
- Bits [1:0] of every newly loaded pc are forced to 0.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. issue_count wraps from 32'hFFFF_FFFF to 0.
- redirect_valid=1 has priority over all other next-state logic in any state:
  - next edge: pc<=redirect_pc & ~3, instr_valid<=0, state<=REQ.
  - An imem_ack in the same cycle is discarded; its data is never issued.
  - A valid&ready handshake in the same cycle still counts (issue_count+=1), but the JAL/+4 target is ignored.
- Reset has priority over redirect and over any outstanding request. A late imem_ack arriving after reset, while imem_req=0, is ignored.
- No instruction is ever issued twice or dropped, except those discarded by redirect or reset.

Test Plan:
- Reset with RESET_PC=0; zero-wait memory returning 32'h0000_0013 (addi nop) at every address; instr_ready=1 -> imem_addr sequence 0,4,8,12; one issue per 2 cycles; issue_count=4 after 4 handshakes.
- JAL at pc=0x10, word 32'h0100_006F (imm=+16) -> next imem_addr=0x20. JAL 32'hFF1F_F06F (imm=-16) at 0x20 -> next imem_addr=0x10.
- Memory ack delayed 3 cycles; instr_ready low for 2 cycles -> imem_addr stable throughout the wait; instr/instr_pc stable while stalled; one issue only.
- redirect_valid with redirect_pc=0x103 while in REQ and imem_ack=1 in the same cycle -> rdata discarded; next imem_addr=0x100; instr_valid stays 0.
- Simultaneous handshake on JAL and redirect to 0x40 -> issue_count increments; next imem_addr=0x40, not the JAL target.
- pc=32'hFFFF_FFFC non-JAL issue -> next imem_addr=0. Assert reset mid-wait (imem_req=1, no ack) -> next cycle imem_req=0, pc=RESET_PC, issue_count=0. A stray ack afterwards has no effect.
